// File: rtl/rect_raster_engine.sv
// Rectangle rasterizer: walks a clipped, normalized rectangle in raster order
// and emits one framebuffer pixel write per valid/ready handshake.
module rect_raster_engine #(
    parameter int COORD_W = 8,
    parameter int COLOR_W = 8,
    parameter int FB_W    = 160,
    parameter int FB_H    = 120,
    parameter int ADDR_W  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] xs,
    input  logic [COORD_W-1:0] ys,
    input  logic [COORD_W-1:0] xe,
    input  logic [COORD_W-1:0] ye,
    input  logic [COLOR_W-1:0] color,
    input  logic               mode,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               done
);

    localparam logic [COORD_W-1:0] XMAX = COORD_W'(FB_W - 1);
    localparam logic [COORD_W-1:0] YMAX = COORD_W'(FB_H - 1);
    localparam logic [ADDR_W-1:0]  ROW  = ADDR_W'(FB_W);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        FIN
    } state_t;

    state_t state;

    logic [COORD_W-1:0] xs_r, ys_r, xe_r, ye_r;
    logic [COLOR_W-1:0] col_r;
    logic               mode_r;
    logic [COORD_W-1:0] x0, x1, y0, y1;
    logic [ADDR_W-1:0]  rowbase;

    logic [COORD_W-1:0] cxs, cxe, cys, cye;
    logic [COORD_W-1:0] nx0, nx1, ny0, ny1;

    always_comb begin
        cxs = (xs_r > XMAX) ? XMAX : xs_r;
        cxe = (xe_r > XMAX) ? XMAX : xe_r;
        cys = (ys_r > YMAX) ? YMAX : ys_r;
        cye = (ye_r > YMAX) ? YMAX : ye_r;
        nx0 = (cxs < cxe) ? cxs : cxe;
        nx1 = (cxs < cxe) ? cxe : cxs;
        ny0 = (cys < cye) ? cys : cye;
        ny1 = (cys < cye) ? cye : cys;
    end

    logic hs, row_end, last, edge_row;

    always_comb begin
        hs       = pix_valid && pix_ready;
        row_end  = (pix_x == x1);
        last     = row_end && (pix_y == y1);
        edge_row = (pix_y == y0) || (pix_y == y1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pix_valid <= 1'b0;
            done      <= 1'b0;
            pix_addr  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            xs_r      <= '0;
            ys_r      <= '0;
            xe_r      <= '0;
            ye_r      <= '0;
            col_r     <= '0;
            mode_r    <= 1'b0;
            x0        <= '0;
            x1        <= '0;
            y0        <= '0;
            y1        <= '0;
            rowbase   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xs_r   <= xs;
                        ys_r   <= ys;
                        xe_r   <= xe;
                        ye_r   <= ye;
                        col_r  <= color;
                        mode_r <= mode;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    x0        <= nx0;
                    x1        <= nx1;
                    y0        <= ny0;
                    y1        <= ny1;
                    pix_x     <= nx0;
                    pix_y     <= ny0;
                    pix_color <= col_r;
                    // One constant multiply per command; RUN only adds.
                    rowbase   <= ADDR_W'(ny0) * ROW;
                    pix_addr  <= ADDR_W'(ny0) * ROW + ADDR_W'(nx0);
                    pix_valid <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (hs) begin
                        if (last) begin
                            pix_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
                        end else if (row_end) begin
                            pix_x    <= x0;
                            pix_y    <= pix_y + 1'b1;
                            rowbase  <= rowbase + ROW;
                            pix_addr <= rowbase + ROW + ADDR_W'(x0);
                        end else if (mode_r && !edge_row) begin
                            // Outline interior rows jump straight to the right edge.
                            pix_x    <= x1;
                            pix_addr <= rowbase + ADDR_W'(x1);
                        end else begin
                            pix_x    <= pix_x + 1'b1;
                            pix_addr <= pix_addr + 1'b1;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_raster_engine.sv
// Directed bench for rect_raster_engine: pixel streams, latency,
// backpressure, clipping and mid-run reset.
module tb_rect_raster_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  xs, ys, xe, ye;
    logic [7:0]  color;
    logic        mode;
    logic        busy;
    logic        pix_valid;
    logic        pix_ready;
    logic [14:0] pix_addr;
    logic [7:0]  pix_x, pix_y;
    logic [7:0]  pix_color;
    logic        done;

    rect_raster_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .xs        (xs),
        .ys        (ys),
        .xe        (xe),
        .ye        (ye),
        .color     (color),
        .mode      (mode),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_addr  (pix_addr),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int got_addr[$];
    int got_slot[$];
    int got_col[$];
    int exp_addr[$];
    int ref_addr[$];
    int done_cnt, done_gap, done_busy, unstable, lat0_v, lat0_b, lat1_v;

    task automatic build_exp(input int a, b, c, d, input bit md);
        int x0, x1, y0, y1;
        a = (a > 159) ? 159 : a;
        c = (c > 159) ? 159 : c;
        b = (b > 119) ? 119 : b;
        d = (d > 119) ? 119 : d;
        x0 = (a < c) ? a : c;
        x1 = (a < c) ? c : a;
        y0 = (b < d) ? b : d;
        y1 = (b < d) ? d : b;
        exp_addr.delete();
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                if (!md || y == y0 || y == y1 || x == x0 || x == x1)
                    exp_addr.push_back(y * 160 + x);
    endtask

    function automatic int stream_bad();
        int nb = 0;
        if (got_addr.size() != exp_addr.size()) return 1;
        foreach (got_addr[i]) if (got_addr[i] != exp_addr[i]) nb++;
        return nb;
    endfunction

    task automatic run_cmd(input int a, b, c, d, input int col, input bit md,
                           input bit toggle, input bit midstart);
        int last_hs = -1;
        bit fin = 0;
        bit pv = 0, pr = 0;
        int px = 0, pa = 0;
        got_addr.delete();
        got_slot.delete();
        got_col.delete();
        done_cnt = 0;
        done_gap = -1;
        done_busy = -1;
        unstable = 0;
        @(posedge clk); #1;
        xs = 8'(a); ys = 8'(b); xe = 8'(c); ye = 8'(d);
        color = 8'(col); mode = md; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        xs = 8'd0; ys = 8'd0; xe = 8'd0; ye = 8'd0;
        lat0_v = int'(pix_valid);
        lat0_b = int'(busy);
        @(posedge clk); #1;
        lat1_v = int'(pix_valid);
        for (int slot = 0; slot < 3000; slot++) begin
            pix_ready = toggle ? (slot % 2 == 0) : 1'b1;
            start = (midstart && slot == 3);
            if (start) begin
                xs = 8'd9; ys = 8'd9; xe = 8'd9; ye = 8'd9;
            end
            if (pv && !pr)
                if (!pix_valid || pix_x != 8'(px) || pix_addr != 15'(pa))
                    unstable++;
            if (done) begin
                done_cnt++;
                done_gap = slot - last_hs;
                done_busy = int'(busy);
                fin = 1;
            end
            if (pix_valid && pix_ready) begin
                got_addr.push_back(int'(pix_addr));
                got_slot.push_back(slot);
                got_col.push_back(int'(pix_color));
                last_hs = slot;
            end
            pv = pix_valid; pr = pix_ready;
            px = int'(pix_x); pa = int'(pix_addr);
            if (fin) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!fin) check("timeout", 0, 1);
        @(posedge clk); #1;
        if (done) done_cnt++;
    endtask

    initial begin
        int badcol, nd, gap;
        rst_n = 1'b0; start = 1'b0; pix_ready = 1'b1;
        xs = 0; ys = 0; xe = 0; ye = 0; color = 0; mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(pix_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(pix_addr), 0);
        check("rst_xy", int'(pix_x) + int'(pix_y), 0);
        check("rst_color", int'(pix_color), 0);
        rst_n = 1'b1;

        // Filled 51x31
        run_cmd(0, 0, 50, 30, 10, 0, 0, 0);
        build_exp(0, 0, 50, 30, 0);
        check("lat_load_busy", lat0_b, 1);
        check("lat_load_valid", lat0_v, 0);
        check("lat_run_valid", lat1_v, 1);
        check("fill_count", got_addr.size(), 1581);
        check("fill_first", got_addr[0], 0);
        check("fill_row1", got_addr[51], 160);
        check("fill_last", got_addr[got_addr.size() - 1], 4850);
        check("fill_stream", stream_bad(), 0);
        check("fill_b2b", got_slot[got_slot.size() - 1], 1580);
        check("fill_done_cnt", done_cnt, 1);
        check("fill_done_gap", done_gap, 1);
        check("fill_done_busy", done_busy, 0);
        badcol = 0;
        foreach (got_col[i]) if (got_col[i] != 10) badcol++;
        check("fill_color", badcol, 0);
        ref_addr = got_addr;

        // Swapped corners
        run_cmd(50, 30, 0, 0, 10, 0, 0, 0);
        exp_addr = ref_addr;
        check("swap_stream", stream_bad(), 0);

        // Outline 5x4
        run_cmd(10, 10, 14, 13, 3, 1, 0, 0);
        build_exp(10, 10, 14, 13, 1);
        check("ol_count", got_addr.size(), 14);
        check("ol_stream", stream_bad(), 0);
        check("ol_first", got_addr[0], 1610);
        check("ol_r11a", got_addr[5], 1770);
        check("ol_r11b", got_addr[6], 1774);
        check("ol_r11_b2b", got_slot[6] - got_slot[5], 1);
        check("ol_last", got_addr[13], 2094);

        // Backpressure with a stray start mid-run
        run_cmd(0, 0, 3, 0, 7, 0, 1, 1);
        build_exp(0, 0, 3, 0, 0);
        check("bp_count", got_addr.size(), 4);
        check("bp_stream", stream_bad(), 0);
        check("bp_stable", unstable, 0);
        check("bp_done_cnt", done_cnt, 1);

        // Clipping
        run_cmd(150, 110, 200, 255, 5, 0, 0, 0);
        build_exp(150, 110, 200, 255, 0);
        check("clip_count", got_addr.size(), 100);
        check("clip_first", got_addr[0], 17750);
        check("clip_last", got_addr[got_addr.size() - 1], 19199);
        check("clip_stream", stream_bad(), 0);

        // Reset mid-run
        @(posedge clk); #1;
        xs = 0; ys = 0; xe = 50; ye = 30; mode = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pix_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(pix_valid), 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || pix_valid) nd++;
            @(posedge clk); #1;
        end
        check("mid_rst_quiet", nd, 0);
        run_cmd(5, 5, 5, 5, 9, 0, 0, 0);
        check("single_count", got_addr.size(), 1);
        check("single_addr", got_addr.size() > 0 ? got_addr[0] : -1, 805);
        gap = done_gap;
        check("single_done_gap", gap, 1);
        check("single_done_cnt", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_raster_engine.md
Name: rect_raster_engine

Overview:
- Downstream consumer of the command/control unit. It takes one decoded rectangle command (Xs, Ys, Xe, Ye, color, mode) and walks it in raster order.
- It emits one framebuffer pixel write per accepted handshake, with address y*FB_W + x, to the framebuffer write port.
- It supports filled rectangles and 1-pixel outlines, clips coordinates to the framebuffer, and tolerates swapped corners.

Parameters:
- COORD_W, 8, width of each coordinate input.
- COLOR_W, 8, width of color.
- FB_W, 160, framebuffer width in pixels.
- FB_H, 120, framebuffer height in pixels.
- ADDR_W, 15, pixel address width; must satisfy 2^ADDR_W >= FB_W*FB_H.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle command strobe from the command unit.
- xs  in  COORD_W  start X corner.
- ys  in  COORD_W  start Y corner.
- xe  in  COORD_W  end X corner.
- ye  in  COORD_W  end Y corner.
- color  in  COLOR_W  fill/outline color.
- mode  in  1  0 = filled, 1 = outline.
- busy  out  1  high from the start-accept cycle until done.
- pix_valid  out  1  pixel write request.
- pix_ready  in  1  framebuffer accepts the pixel this cycle.
- pix_addr  out  ADDR_W  y*FB_W + x.
- pix_x  out  COORD_W  current X.
- pix_y  out  COORD_W  current Y.
- pix_color  out  COLOR_W  latched color.
- done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State returns to IDLE from any state, including mid-RUN.
  - busy, pix_valid, done, pix_addr, pix_x, pix_y and pix_color all go to 0.
  - No partial command is retained.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 latches xs, ys, xe, ye, color and mode, and moves to LOAD.
  - busy goes high the next cycle.
  - start while not in IDLE is ignored; no queuing.
- LOAD, exactly one cycle:
  - Clip each X to min(v, FB_W-1) and each Y to min(v, FB_H-1).
  - Normalize: x0 = min(xs, xe), x1 = max(xs, xe); y0 and y1 likewise.
  - Set the current position to (x0, y0).
  - Compute the address incrementally; no multiplier in RUN. Row base increments by FB_W per row.
- RUN:
  - pix_valid=1. pix_x, pix_y, pix_addr and pix_color stay stable until pix_ready=1 (AXI-like; valid is never dropped without ready).
  - On a handshake, advance in row-major order: x++ until x1, then x = x0 and y++.
  - The handshake on (x1, y1) moves to DONE; pix_valid drops in the same edge.
- Latency: start at edge N -> first pix_valid=1 after edge N+2. Throughput is 1 pixel/clk with pix_ready held high.
- Outline mode (mode=1):
  - Rows y0 and y1 emit every x in x0..x1.
  - Interior rows emit only x0, then x1, with no bubble between them.
  - If x0==x1 each row emits one pixel; if y0==y1 a single row is emitted.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in the DONE cycle is ignored.
- Degenerate case xs==xe and ys==ye: exactly one pixel.
- Pixel count: filled = (x1-x0+1)*(y1-y0+1). Outline = filled count when width<=2 or height<=2, else 2*(x1-x0+1) + 2*(y1-y0-1).
- pix_addr never exceeds FB_W*FB_H-1.
- pix_valid, done and busy are registered outputs.

Test Plan:
- Fill, xs=0, ys=0, xe=50, ye=30, color=10, pix_ready=1:
  - 1581 pixels on consecutive cycles.
  - First addr=0; addr 160 at (0,1); last addr=4850.
  - done once, 1 cycle after the last handshake.
- Swapped corners xs=50, ys=30, xe=0, ye=0 -> identical pixel stream to the previous case.
- Outline, (10,10)-(14,13), mode=1 -> 14 pixels.
  - Row 11 emits only x=10 and x=14, back-to-back.
  - Addresses 1610..1614, 1770, 1774, ..., 2090..2094.
- Backpressure: toggle pix_ready every cycle on (0,0)-(3,0):
  - 4 pixels.
  - pix_x/pix_addr stay stable while ready=0.
  - No pixel is dropped or duplicated.
  - A start pulse mid-run is ignored.
- Clipping (150,110)-(200,255) fill:
  - x range 150..159, y range 110..119, 100 pixels.
  - Last addr=19199.
- Reset: rst_n=0 for one cycle mid-RUN:
  - Next cycle busy=0 and pix_valid=0, no done pulse.
  - A new single-pixel command (5,5)-(5,5) then yields addr=805 and done.
